serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single `full_adder` instance over WIDTH clock cycles to add two WIDTH-bit operands. It latches the operands on a start request, feeds one bit pair per cycle, LSB first, into the full adder, and registers the carry between cycles. It then presents the assembled sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath or FSM and the shared 1-bit adder cell, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new addition; sampled only in IDLE or DONE.
- `a` input WIDTH: operand A; sampled in the cycle `start` is accepted.
- `b` input WIDTH: operand B; sampled in the cycle `start` is accepted.
- `cin` input 1: initial carry-in; sampled in the cycle `start` is accepted.
- `busy` output 1: high while bits are being processed (RUN state).
- `done` output 1: single-cycle pulse when the result is valid.
- `sum` output WIDTH: registered result; holds its value until the next completion.
- `cout` output 1: registered final carry; holds its value until the next completion.
- `ovf` output 1: signed overflow flag; present only with `SERIAL_ADD_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - With `start`=1: load `a` and `b` into shift registers, load `cin` into the carry register, clear the bit counter, go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each cycle:
  - The full adder takes the LSB of A, the LSB of B and the carry register.
  - Its sum bit shifts into the MSB of the result shift register.
  - Its carry-out overwrites the carry register.
  - The A and B shift registers shift right by one; the counter increments.
  - When the counter reaches WIDTH-1, load `sum` from the result shift (including this cycle's bit) and `cout` from this cycle's carry-out, then go to DONE.
- **DONE:**
  - `done`=1 for exactly this cycle.
  - With `start`=1: accept a new operation exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `start` in RUN is ignored. No queuing; operands are not re-sampled.
- Input operands may change freely after the accept cycle.
- Arithmetic: `{cout,sum}` = `a` + `b` + `cin`, modulo 2^(WIDTH+1). No truncation beyond that.
- **Reset**, at any time including mid-RUN:
  - State returns to IDLE and the in-flight operation is discarded.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Counter, carry and shift registers clear to 0.

## Timing
- Start accepted at edge 0. RUN occupies edges 1..WIDTH. `done` is high in the cycle after edge WIDTH.
- Latency: start to done = WIDTH+1 cycles. For WIDTH=8, `done` is visible 9 cycles after `start`.
- `busy` is high for exactly WIDTH cycles per operation.
- `sum`, `cout` and `ovf` change only on the edge entering DONE. They are stable whenever `done`=1.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Add the `ovf` port.
  - On the final RUN cycle, `ovf` = carry into the MSB XOR carry out of the MSB.
  - `ovf` is registered alongside `sum`.
- `SERIAL_ADD_OVF_EN` undefined:
  - No `ovf` port and no extra register.
  - All other behaviour is identical.

## Structure
- Shared package/include holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
  - Counter-width macro: clog2 of WIDTH.
- Instantiates exactly one existing `full_adder` as its sub-module. No new sub-module.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0; `done` exactly 9 cycles after `start`; `busy` high 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- `SERIAL_ADD_OVF_EN` defined:
  - a=0x7F, b=0x01 -> sum=0x80, ovf=1.
  - a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
  - a=0x10, b=0x20 -> ovf=0.
- `start` pulsed with a=0x01, b=0x01 during RUN of 0x10+0x20 -> ignored; result sum=0x30; only one `done` pulse.
- `start` held high in the DONE cycle with new operands 0x0F+0x01 -> second `done` 9 cycles later with sum=0x10; first result 0x30 held until then.
- Assert `rst` at RUN cycle 4 -> all outputs 0 and state IDLE immediately (asynchronous); no `done`. A subsequent 0x12+0x34 yields sum=0x46.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// State encoding, default operand width and counter-width helper.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must index 0..WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial adder controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sequences one full_adder over WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and datapath strobes; start outside IDLE/DONE is ignored.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= fa_cout;
        res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
        cnt    <= cnt + CW'(1);
      end
      // Final bit: carry register still holds the carry into the MSB.
      if (last) begin
        sum  <= {fa_sum, res_sh[WIDTH-1:1]};
        cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
        ovf  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a result scoreboard.
// Checks ovf too when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  exp_t sb[$];
  int   errors;
  int   checks;
  int   done_seen;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    exp_t e;
    logic [8:0] t;
    t      = {1'b0, ta} + {1'b0, tb_} + 9'(tc);
    e.sum  = t[7:0];
    e.cout = t[8];
    e.ovf  = (ta[7] == tb_[7]) && (t[7] != ta[7]);
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      done_seen++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL done_unexpected: queue size %0d, required >0", sb.size());
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Call at a negedge; drives one op, checks latency and busy length.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    int cyc;
    int bcnt;
    push_exp(ta, tb_, tc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      cyc++;
      if (busy === 1'b1) bcnt++;
    end while (done !== 1'b1 && cyc < 40);
    check("latency", 32'(cyc), 32'd9);
    check("busy_cycles", 32'(bcnt), 32'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int cyc;
    errors = 0; checks = 0; done_seen = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h5A, 8'h33, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);

    // start pulsed mid-RUN must be ignored
    d0 = done_seen;
    push_exp(8'h10, 8'h20, 1'b0);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("single_done", 32'(done_seen - d0), 32'd1);
    check("ignored_sum", 32'(sum), 32'h30);

    // back-to-back: start held in the DONE cycle
    push_exp(8'h10, 8'h20, 1'b0);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk); start = 1'b0; cyc++;
    end while (done !== 1'b1 && cyc < 40);
    check("first_done", 32'(done), 32'd1);
    push_exp(8'h0F, 8'h01, 1'b0);
    a = 8'h0F; b = 8'h01; start = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk); start = 1'b0; cyc++;
      if (done === 1'b1 || cyc >= 40) break;
      check("hold_sum", 32'(sum), 32'h30);
    end
    check("b2b_latency", 32'(cyc), 32'd9);
    check("b2b_sum", 32'(sum), 32'h10);
    @(negedge clk);

    // asynchronous reset in the middle of RUN
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    check("arst_state", 32'(dut.state), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("arst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;
    d0 = done_seen;
    repeat (15) @(negedge clk);
    check("no_done_after_rst", 32'(done_seen), 32'(d0));
    run_op(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    check("queue_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
